scoot_bot: RTL and testbench

SCOOT_BOT -- requirements
Module: scoot_bot

---
 rtl/scoot_bot.sv | 107 ++++++++++
 tb/tb_scoot_bot.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/scoot_bot.sv
// scoot_bot: reactive pellet-chasing move generator.
// Inputs lUp/lRight/lDown/lLeft flag a pellet in the adjacent cell.
// Outputs mUp/mRight/mDown/mLeft are registered one-hot move commands.
// With no pellet in view, a 16-bit Galois LFSR picks keep/cw/ccw.
// No position or world model is kept; a move is re-issued every cycle.
module scoot_bot #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lUp,
    input  logic lRight,
    input  logic lDown,
    input  logic lLeft,
    output logic mUp,
    output logic mRight,
    output logic mDown,
    output logic mLeft
);

    // An all-zero Galois LFSR would lock up, so a zero seed becomes 1.
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] POLY = 16'hB400;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    logic [1:0]  heading;
    logic [1:0]  headingNext;
    logic        active;
    logic [3:0]  lQ;
    logic [15:0] lfsr;
    logic [15:0] lfsrNext;
    logic [3:0]  move;
    logic [3:0]  moveNext;

    logic [1:0]  dirCw;
    logic [1:0]  dirCcw;
    logic [1:0]  dirRev;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            heading <= DIR_UP;
            active  <= 1'b0;
            lQ      <= 4'b0000;
            lfsr    <= SEED;
            move    <= 4'b0000;
        end else begin
            heading <= headingNext;
            active  <= 1'b1;
            lQ      <= {lLeft, lDown, lRight, lUp};
            lfsr    <= lfsrNext;
            move    <= moveNext;
        end
    end

    // Next-state logic
    always_comb begin
        dirCw  = heading + 2'd1;
        dirCcw = heading + 2'd3;
        dirRev = heading + 2'd2;

        lfsrNext = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? POLY : 16'h0000);

        headingNext = heading;
        if (active) begin
            if (|lQ) begin
                // Prefer going straight, then cw, then ccw; reverse last.
                priority case (1'b1)
                    lQ[heading]: headingNext = heading;
                    lQ[dirCw]:   headingNext = dirCw;
                    lQ[dirCcw]:  headingNext = dirCcw;
                    default:     headingNext = dirRev;
                endcase
            end else begin
                // Exploration wanders but never doubles back.
                unique case (lfsr[1:0])
                    2'b01:   headingNext = dirCw;
                    2'b10:   headingNext = dirCcw;
                    default: headingNext = heading;
                endcase
            end
        end
    end

    // Output logic: the move register tracks the heading being loaded,
    // and every non-reset edge leaves the block active.
    always_comb begin
        moveNext = 4'b0000;
        unique case (headingNext)
            DIR_UP:    moveNext = 4'b0001;
            DIR_RIGHT: moveNext = 4'b0010;
            DIR_DOWN:  moveNext = 4'b0100;
            DIR_LEFT:  moveNext = 4'b1000;
            default:   moveNext = 4'b0000;
        endcase
    end

    assign mUp    = move[0];
    assign mRight = move[1];
    assign mDown  = move[2];
    assign mLeft  = move[3];

endmodule

// File: tb/tb_scoot_bot.sv
// tb_scoot_bot: randomized and directed checks of scoot_bot against
// a behavioural model of heading choice and LFSR exploration.
module tb_scoot_bot;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] lIn = 4'b0000;
    logic       mUp, mRight, mDown, mLeft;
    logic [3:0] mv;

    int nChecks = 0;
    int nFails  = 0;

    // Behavioural model state
    int mHead;
    bit mAct;
    int mLq;
    int mLfsr;

    scoot_bot dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .lUp    (lIn[0]),
        .lRight (lIn[1]),
        .lDown  (lIn[2]),
        .lLeft  (lIn[3]),
        .mUp    (mUp),
        .mRight (mRight),
        .mDown  (mDown),
        .mLeft  (mLeft)
    );

    assign mv = {mLeft, mDown, mRight, mUp};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int expMove();
        return mAct ? (1 << mHead) : 0;
    endfunction

    function automatic int pickDir();
        int order[4];
        int d;
        order = '{0, 1, 3, 2};
        if (mLq != 0) begin
            for (int k = 0; k < 4; k++) begin
                d = (mHead + order[k]) % 4;
                if ((mLq >> d) % 2 == 1) return d;
            end
            return mHead;
        end
        case (mLfsr % 4)
            1:       return (mHead + 1) % 4;
            2:       return (mHead + 3) % 4;
            default: return mHead;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mHead = 0;
            mAct  = 0;
            mLq   = 0;
            mLfsr = 'hACE1;
        end else begin
            int lsb;
            if (mAct) mHead = pickDir();
            mAct  = 1;
            mLq   = int'(lIn);
            lsb   = mLfsr % 2;
            mLfsr = mLfsr / 2;
            if (lsb == 1) mLfsr = mLfsr ^ 'hB400;
        end
    end

    // Called at a negedge; returns at the next negedge.
    task automatic step(input logic [3:0] l);
        lIn = l;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset(input logic [3:0] lRel);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(4'($urandom));
            chk("rst_out", int'(mv), 0);
        end
        rst_n = 1'b1;
        step(lRel);
        chk("rel_up", int'(mv), 1);
        chk("rel_model", int'(mv), expMove());
    endtask

    initial begin
        logic [3:0] prev;
        logic [3:0] l;

        mHead = 0;
        mAct  = 0;
        mLq   = 0;
        mLfsr = 'hACE1;
        @(negedge clk);

        // Reset and straight ahead
        doReset(4'b0001);
        for (int i = 0; i < 20; i++) begin
            step(4'b0001);
            chk("straight", int'(mv), 1);
        end

        // Turn priority: right wins over left
        step(4'b1010);
        chk("prio_hold", int'(mv), 1);
        step(4'b1010);
        chk("prio_right", int'(mv), 2);
        chk("prio_model", int'(mv), expMove());
        for (int i = 0; i < 3; i++) begin
            step(4'b1010);
            chk("prio_stable", int'(mv), 2);
        end

        // Mid-run asynchronous reset while moving right
        #1 rst_n = 1'b0;
        #1 chk("midrst", int'(mv), 0);
        @(negedge clk);
        doReset(4'b0001);

        // Single target left
        step(4'b1000);
        step(4'b1000);
        chk("single_left", int'(mv), 8);

        // Reverse only
        doReset(4'b0001);
        step(4'b0100);
        step(4'b0100);
        chk("reverse_down", int'(mv), 4);
        chk("reverse_model", int'(mv), expMove());

        // Explore from the default seed
        doReset(4'b0000);
        prev = mv;
        for (int i = 0; i < 1000; i++) begin
            step(4'b0000);
            chk("expl_model", int'(mv), expMove());
            chk("expl_onehot", $countones(mv), 1);
            chk("expl_norev", int'(mv == {prev[1:0], prev[3:2]}), 0);
            prev = mv;
        end

        // Random sensors with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                doReset(4'($urandom));
            end else begin
                l = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
                step(l);
                chk("rand_model", int'(mv), expMove());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
